// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR bank: default feedback taps, draw FSM states
// and the power-of-two mask helper used by rejection sampling.
package lfsr_pkg;

    localparam logic [15:0] DEFAULT_TAPS = 16'hD008;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } draw_state_e;

    // Smallest all-ones mask covering [0, limit): 2^ceil(log2(limit)) - 1.
    function automatic logic [63:0] pow2_mask(input logic [63:0] limit);
        logic [63:0] m;
        logic [63:0] mask;
        m    = limit - 64'd1;
        mask = '0;
        for (int i = 0; i < 64; i++) begin
            if (m[i]) mask = (64'd1 << (i + 1)) - 64'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_cell.sv
// One Fibonacci LFSR channel: shifts left with the tap parity as the new LSB.
// A load overrides the step; a zero load value restores SEED to avoid lockup.
module lfsr_cell import lfsr_pkg::*; #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    // NOTE: non-blocking assignment for registered state so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SEED;
        else      state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_bank.sv
// Bank of CHANNELS LFSRs plus a bounded-draw port using rejection sampling.
// Optional seed loading is enabled by defining LFSR_SEED_LOAD_EN.
module lfsr_bank import lfsr_pkg::*; #(
    parameter int               WIDTH     = 16,
    parameter int               CHANNELS  = 9,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
    parameter int               MAX_TRIES = 8,
    localparam int              CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [CHANNELS*WIDTH-1:0] nums,
    input  logic                      draw_req,
    output logic                      draw_ready,
    input  logic [CH_W-1:0]           draw_ch,
    input  logic [WIDTH-1:0]          draw_limit,
    output logic                      draw_valid,
    output logic [WIDTH-1:0]          draw_value
`ifdef LFSR_SEED_LOAD_EN
    ,
    input  logic                      seed_load,
    input  logic [CH_W-1:0]           seed_ch,
    input  logic [WIDTH-1:0]          seed_val
`endif
);

    localparam int              TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    draw_state_e      state_q;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] value_q;
    logic [TRY_W-1:0] tries_q;
    logic [CH_W-1:0]  ch_q;
    logic [WIDTH-1:0] limit_q;

    logic [WIDTH-1:0] state_w [CHANNELS];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             force_step;
    logic [CH_W-1:0]  ch_sel;

    assign cur    = state_w[ch_q];
    assign mask   = WIDTH'(pow2_mask(64'(limit_q)));
    assign cand   = cur & mask;
    assign accept = (limit_q == '0) || (cand < limit_q) || (tries_q == LAST_TRY);
    // cand >= limit here, and cand < 2*limit, so the fallback stays in range.
    assign result = (limit_q == '0)  ? cur  :
                    (cand < limit_q) ? cand : cand - limit_q;
    assign force_step = (state_q == EVAL) && !accept;
    assign ch_sel     = (32'(draw_ch) < CHANNELS) ? draw_ch : '0;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam logic [WIDTH-1:0] SEED_K = WIDTH'(1) << (k % WIDTH);
        logic             load_k;
        logic [WIDTH-1:0] load_val_k;
`ifdef LFSR_SEED_LOAD_EN
        assign load_k     = seed_load && (32'(seed_ch) == k);
        assign load_val_k = seed_val;
`else
        assign load_k     = 1'b0;
        assign load_val_k = '0;
`endif
        lfsr_cell #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .SEED  (SEED_K)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .step     (en || (force_step && (32'(ch_q) == k))),
            .load     (load_k),
            .load_val (load_val_k),
            .state    (state_w[k])
        );
        assign nums[k*WIDTH +: WIDTH] = state_w[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            value_q <= '0;
            tries_q <= '0;
            ch_q    <= '0;
            limit_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (draw_req && ready_q) begin
                        ch_q    <= ch_sel;
                        limit_q <= draw_limit;
                        tries_q <= '0;
                        ready_q <= 1'b0;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (accept) begin
                        value_q <= result;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign draw_ready = ready_q;
    assign draw_valid = valid_q;
    assign draw_value = value_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// Directed bench for lfsr_bank: reset seeds, stepping, period, bounded draws,
// rejection/fallback (second instance with MAX_TRIES=1), reset mid-draw, seed loads.
module tb_lfsr_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [143:0] nums;
    logic         draw_req;
    logic         draw_ready;
    logic [3:0]   draw_ch;
    logic [15:0]  draw_limit;
    logic         draw_valid;
    logic [15:0]  draw_value;
`ifdef LFSR_SEED_LOAD_EN
    logic         seed_load;
    logic [3:0]   seed_ch;
    logic [15:0]  seed_val;
`endif

    logic         en2;
    logic [31:0]  nums2;
    logic         req2;
    logic         ready2;
    logic         ch2;
    logic [15:0]  limit2;
    logic         valid2;
    logic [15:0]  value2;
`ifdef LFSR_SEED_LOAD_EN
    logic         seed_load2;
    logic         seed_ch2;
    logic [15:0]  seed_val2;
`endif

    int checks   = 0;
    int failures = 0;

    lfsr_bank u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .nums       (nums),
        .draw_req   (draw_req),
        .draw_ready (draw_ready),
        .draw_ch    (draw_ch),
        .draw_limit (draw_limit),
        .draw_valid (draw_valid),
        .draw_value (draw_value)
`ifdef LFSR_SEED_LOAD_EN
        ,
        .seed_load  (seed_load),
        .seed_ch    (seed_ch),
        .seed_val   (seed_val)
`endif
    );

    lfsr_bank #(.WIDTH(16), .CHANNELS(2), .MAX_TRIES(1)) u_rej (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
        .nums       (nums2),
        .draw_req   (req2),
        .draw_ready (ready2),
        .draw_ch    (ch2),
        .draw_limit (limit2),
        .draw_valid (valid2),
        .draw_value (value2)
`ifdef LFSR_SEED_LOAD_EN
        ,
        .seed_load  (seed_load2),
        .seed_ch    (seed_ch2),
        .seed_val   (seed_val2)
`endif
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] ch_of(input int k);
        return nums[k*16 +: 16];
    endfunction

    function automatic logic [15:0] step16(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hD008)};
    endfunction

    // Issues one draw from a negedge with draw_ready=1; returns at the negedge
    // where draw_valid is seen (or after a cycle budget).
    task automatic do_draw(input logic [3:0] ch, input logic [15:0] lim,
                           output logic [15:0] val, output int cyc, output bit ok);
        draw_ch    = ch;
        draw_limit = lim;
        draw_req   = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!draw_valid && cyc < 20);
        ok  = draw_valid;
        val = draw_value;
    endtask

    task automatic test_reset;
        checks++; if (ch_of(0) !== 16'h0001) begin failures++; $display("FAIL reset_ch0: got %h expected 0001", ch_of(0)); end
        checks++; if (ch_of(3) !== 16'h0008) begin failures++; $display("FAIL reset_ch3: got %h expected 0008", ch_of(3)); end
        checks++; if (ch_of(8) !== 16'h0100) begin failures++; $display("FAIL reset_ch8: got %h expected 0100", ch_of(8)); end
        checks++; if (draw_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", draw_ready); end
        checks++; if (draw_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", draw_valid); end
        checks++; if (draw_value !== 16'h0000) begin failures++; $display("FAIL reset_value: got %h expected 0000", draw_value); end
    endtask

    task automatic test_step;
        en = 1'b1;
        @(negedge clk);
        checks++; if (ch_of(0) !== 16'h0002) begin failures++; $display("FAIL step_ch0: got %h expected 0002", ch_of(0)); end
        checks++; if (ch_of(3) !== 16'h0011) begin failures++; $display("FAIL step_ch3: got %h expected 0011", ch_of(3)); end
        repeat (65534) @(negedge clk);
        en = 1'b0;
        checks++; if (ch_of(0) !== 16'h0001) begin failures++; $display("FAIL period_ch0: got %h expected 0001", ch_of(0)); end
        checks++; if (ch_of(8) !== 16'h0100) begin failures++; $display("FAIL period_ch8: got %h expected 0100", ch_of(8)); end
    endtask

    task automatic test_draw_basic;
        logic [15:0] v;
        int          c;
        bit          ok;
        do_draw(4'd0, 16'd1, v, c, ok);
        checks++; if (!ok || v !== 16'h0000 || c != 1) begin failures++; $display("FAIL draw_lim1: got ok=%0d val=%h cyc=%0d expected ok=1 val=0000 cyc=1", ok, v, c); end
        do_draw(4'd3, 16'd0, v, c, ok);
        checks++; if (!ok || v !== 16'h0008 || c != 1) begin failures++; $display("FAIL draw_lim0: got ok=%0d val=%h cyc=%0d expected ok=1 val=0008 cyc=1", ok, v, c); end
        do_draw(4'd2, 16'd3, v, c, ok);
        checks++; if (!ok || v !== 16'h0000 || c != 1) begin failures++; $display("FAIL draw_ch2_lim3: got ok=%0d val=%h cyc=%0d expected ok=1 val=0000 cyc=1", ok, v, c); end
        do_draw(4'd12, 16'd0, v, c, ok);
        checks++; if (!ok || v !== 16'h0001) begin failures++; $display("FAIL draw_ch_oob: got ok=%0d val=%h expected ok=1 val=0001", ok, v); end
    endtask

    task automatic test_back_to_back;
        draw_ch = 4'd8; draw_limit = 16'd0; draw_req = 1'b1;
        @(negedge clk);
        checks++; if (draw_ready !== 1'b0 || draw_valid !== 1'b0) begin failures++; $display("FAIL b2b_busy: got ready=%b valid=%b expected 0 0", draw_ready, draw_valid); end
        draw_ch = 4'd3;   // request held high while busy must not retarget the draw
        @(negedge clk);
        checks++; if (draw_valid !== 1'b1 || draw_value !== 16'h0100 || draw_ready !== 1'b1) begin failures++; $display("FAIL b2b_first: got valid=%b val=%h ready=%b expected 1 0100 1", draw_valid, draw_value, draw_ready); end
        @(negedge clk);
        draw_req = 1'b0;
        checks++; if (draw_valid !== 1'b0 || draw_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept: got valid=%b ready=%b expected 0 0", draw_valid, draw_ready); end
        @(negedge clk);
        checks++; if (draw_valid !== 1'b1 || draw_value !== 16'h0008) begin failures++; $display("FAIL b2b_second: got valid=%b val=%h expected 1 0008", draw_valid, draw_value); end
        @(negedge clk);
    endtask

    task automatic test_reject;
        logic [15:0] v;
        int          c;
        bit          ok;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++; if (ch_of(3) !== 16'h0011) begin failures++; $display("FAIL rej_pre: got %h expected 0011", ch_of(3)); end
        // cand 0x11 >= 17 rejected, ch3 steps to 0x22, cand 2 accepted
        do_draw(4'd3, 16'd17, v, c, ok);
        checks++; if (!ok || v !== 16'h0002 || c != 2) begin failures++; $display("FAIL rej_value: got ok=%0d val=%h cyc=%0d expected ok=1 val=0002 cyc=2", ok, v, c); end
        checks++; if (ch_of(3) !== 16'h0022 || ch_of(0) !== 16'h0002) begin failures++; $display("FAIL rej_force: got ch3=%h ch0=%h expected 0022 0002", ch_of(3), ch_of(0)); end
    endtask

    task automatic test_random;
        logic [15:0] v;
        int          c;
        bit          ok;
        int          bad = 0;
        for (int i = 0; i < 1000; i++) begin
            en = 1'($urandom_range(0, 1));
            do_draw(4'($urandom_range(0, 15)), 16'd6, v, c, ok);
            checks++;
            if (!ok || v >= 16'd6 || c > 8) begin
                failures++;
                if (bad < 5) $display("FAIL rand_draw%0d: got ok=%0d val=%0d cyc=%0d expected ok=1 val<6 cyc<=8", i, ok, v, c);
                bad++;
            end
        end
        en = 1'b0;
    endtask

`ifdef LFSR_SEED_LOAD_EN
    task automatic test_seed_load;
        seed_load = 1'b1; seed_ch = 4'd1; seed_val = 16'hBEEF;
        @(negedge clk);
        seed_load = 1'b0;
        checks++; if (ch_of(1) !== 16'hBEEF) begin failures++; $display("FAIL seed_beef: got %h expected beef", ch_of(1)); end
        seed_load = 1'b1; seed_val = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        checks++; if (ch_of(1) !== 16'h0002) begin failures++; $display("FAIL seed_zero: got %h expected 0002", ch_of(1)); end
    endtask
`endif

    task automatic test_reset_mid_draw;
        draw_ch = 4'd3; draw_limit = 16'd0; draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (draw_ready !== 1'b1 || draw_valid !== 1'b0) begin failures++; $display("FAIL midrst_now: got ready=%b valid=%b expected 1 0", draw_ready, draw_valid); end
        @(negedge clk);
        checks++; if (draw_valid !== 1'b0 || ch_of(3) !== 16'h0008) begin failures++; $display("FAIL midrst_after: got valid=%b ch3=%h expected 0 0008", draw_valid, ch_of(3)); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fallback;
        logic [15:0] m = 16'h0001;
        bit          found = 1'b0;
        checks++; if (nums2[15:0] !== m) begin failures++; $display("FAIL fb_seed: got %h expected 0001", nums2[15:0]); end
        en2 = 1'b1;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            m = step16(m);
            if (m[2:0] == 3'd7) found = 1'b1;
        end
        en2 = 1'b0;
        checks++; if (!found || nums2[15:0] !== m) begin failures++; $display("FAIL fb_state: got %h expected %h found=%0d", nums2[15:0], m, found); end
        req2 = 1'b1; ch2 = 1'b0; limit2 = 16'd5;
        @(negedge clk);
        req2 = 1'b0;
        @(negedge clk);
        checks++; if (valid2 !== 1'b1 || value2 !== 16'd2) begin failures++; $display("FAIL fb_value: got valid=%b val=%0d expected 1 2", valid2, value2); end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; draw_req = 1'b0; draw_ch = '0; draw_limit = '0;
        en2 = 1'b0; req2 = 1'b0; ch2 = 1'b0; limit2 = '0;
`ifdef LFSR_SEED_LOAD_EN
        seed_load = 1'b0; seed_ch = '0; seed_val = '0;
        seed_load2 = 1'b0; seed_ch2 = 1'b0; seed_val2 = '0;
`endif
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b1;
        test_step;
        test_draw_basic;
        test_back_to_back;
        test_reject;
        test_random;
`ifdef LFSR_SEED_LOAD_EN
        test_seed_load;
`endif
        test_reset_mid_draw;
        test_fallback;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
